// File: rtl/clock_pkg.sv
// Shared constants and types for the time-of-day counter slice.
// Holds the hour-mode selectors, digit limits, BCD widths and the hour register layout.
package clock_pkg;

  localparam int unsigned HOUR_MODE_12 = 12;
  localparam int unsigned HOUR_MODE_24 = 24;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

  localparam int unsigned ONES_W      = 4;
  localparam int unsigned HOUR_TENS_W = 2;
  localparam int unsigned MIN_TENS_W  = 3;
  localparam int unsigned SEC_TENS_W  = 3;

  // Hour digits plus the PM flag, advanced together as one unit.
  typedef struct packed {
    logic [HOUR_TENS_W-1:0] tens;
    logic [ONES_W-1:0]      ones;
    logic                   pm;
  } hour_t;

endpackage

// File: rtl/time_of_day_counter_if.sv
// Control pulses and BCD time outputs of the time-of-day counter.
// master: drives tick / set pulses, reads time. slave: the counter itself.
//   i_tick      1 Hz level or pulse, rising edge used
//   i_inc_min   one-cycle pulse, minutes +1
//   i_inc_hour  one-cycle pulse, hours +1
//   i_clr_sec   one-cycle pulse, seconds to 00
//   o_*         BCD digits, PM flag, seconds strobe
interface time_of_day_counter_if;
  import clock_pkg::*;

  logic                   i_tick;
  logic                   i_inc_min;
  logic                   i_inc_hour;
  logic                   i_clr_sec;
  logic [HOUR_TENS_W-1:0] o_hour_tens;
  logic [ONES_W-1:0]      o_hour_ones;
  logic [MIN_TENS_W-1:0]  o_min_tens;
  logic [ONES_W-1:0]      o_min_ones;
  logic [SEC_TENS_W-1:0]  o_sec_tens;
  logic [ONES_W-1:0]      o_sec_ones;
  logic                   o_pm;
  logic                   o_sec_strobe;

  modport master (
    output i_tick, i_inc_min, i_inc_hour, i_clr_sec,
    input  o_hour_tens, o_hour_ones, o_min_tens, o_min_ones,
           o_sec_tens, o_sec_ones, o_pm, o_sec_strobe
  );

  modport slave (
    input  i_tick, i_inc_min, i_inc_hour, i_clr_sec,
    output o_hour_tens, o_hour_ones, o_min_tens, o_min_ones,
           o_sec_tens, o_sec_ones, o_pm, o_sec_strobe
  );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo-(MAX+1) counter advancing 0, 1 or 2 steps per cycle.
// Ports: clk, rst_n (async, active low), clear (priority, to 00), step (0..2),
//        tens/ones (registered digits), wrap_c (a step passed MAX this cycle).
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned MAX    = 59,
  parameter int unsigned TENS_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [1:0]        step,
  output logic [TENS_W-1:0] tens,
  output logic [ONES_W-1:0] ones,
  output logic              wrap_c
);

  localparam int unsigned MAX_TENS = MAX / 10;
  localparam int unsigned MAX_ONES = MAX % 10;

  typedef struct packed {
    logic [TENS_W-1:0] tens;
    logic [ONES_W-1:0] ones;
  } digits_t;

  digits_t val_q, mid_c, nxt_c;

  function automatic logic at_max(input digits_t d);
    return (d.tens == TENS_W'(MAX_TENS)) && (d.ones == ONES_W'(MAX_ONES));
  endfunction

  // Single BCD increment; wrap decided on the full two-digit value.
  function automatic digits_t inc1(input digits_t d);
    digits_t r;
    r = d;
    if (at_max(d)) begin
      r.tens = '0;
      r.ones = '0;
    end else if (d.ones == ONES_W'(9)) begin
      r.tens = d.tens + TENS_W'(1);
      r.ones = '0;
    end else begin
      r.ones = d.ones + ONES_W'(1);
    end
    return r;
  endfunction

  // Chain up to two increments.
  always_comb begin
    mid_c  = inc1(val_q);
    nxt_c  = val_q;
    wrap_c = 1'b0;
    if (step[1]) begin
      nxt_c  = inc1(mid_c);
      wrap_c = at_max(val_q) | at_max(mid_c);
    end else if (step[0]) begin
      nxt_c  = mid_c;
      wrap_c = at_max(val_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
    end else if (clear) begin
      val_q <= '0;
    end else begin
      val_q <= nxt_c;
    end
  end

  assign tens = val_q.tens;
  assign ones = val_q.ones;

endmodule

// File: rtl/time_of_day_counter.sv
// Wall-clock time in BCD, advanced by the rising edge of a 1 Hz tick, with
// manual minute/hour set pulses and a seconds clear. 24-hour or 12-hour+PM.
// Ports: i_clk, i_reset_n (async, active low), bus (time_of_day_counter_if.slave).
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int unsigned HOUR_MODE = HOUR_MODE_24
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  time_of_day_counter_if.slave  bus
);

  localparam logic  IS_12         = (HOUR_MODE == HOUR_MODE_12);
  localparam hour_t HOUR_RESET_12 = '{tens: HOUR_TENS_W'(1), ones: ONES_W'(2), pm: 1'b0};
  localparam hour_t HOUR_RESET_24 = '0;
  localparam hour_t HOUR_RESET    = IS_12 ? HOUR_RESET_12 : HOUR_RESET_24;

  logic                  tick_q;
  logic                  strobe_q;
  logic                  tick_edge_c;
  logic                  sec_adv_c;
  logic                  sec_wrap_c;
  logic                  min_wrap_c;
  logic                  hour_carry_c;
  logic [1:0]            min_step_c;
  logic [1:0]            hour_step_c;
  logic [MIN_TENS_W-1:0] min_tens;
  logic [ONES_W-1:0]     min_ones;
  hour_t                 hour_q, hour_mid_c, hour_nxt_c;

  // Reset leaves tick_q low so a tick already high at release counts as an edge.
  assign tick_edge_c = bus.i_tick & ~tick_q;
  assign sec_adv_c   = tick_edge_c & ~bus.i_clr_sec;

  bcd_mod_counter #(.MAX(SEC_MAX), .TENS_W(SEC_TENS_W)) u_sec (
    .clk    (i_clk),
    .rst_n  (i_reset_n),
    .clear  (bus.i_clr_sec),
    .step   ({1'b0, sec_adv_c}),
    .tens   (bus.o_sec_tens),
    .ones   (bus.o_sec_ones),
    .wrap_c (sec_wrap_c)
  );

  assign min_step_c = {1'b0, sec_wrap_c} + {1'b0, bus.i_inc_min};

  bcd_mod_counter #(.MAX(MIN_MAX), .TENS_W(MIN_TENS_W)) u_min (
    .clk    (i_clk),
    .rst_n  (i_reset_n),
    .clear  (1'b0),
    .step   (min_step_c),
    .tens   (min_tens),
    .ones   (min_ones),
    .wrap_c (min_wrap_c)
  );

  // Only the tick carry out of minute 59 reaches the hours; a same-cycle
  // manual minute step can wrap minutes without carrying.
  assign hour_carry_c = sec_wrap_c & min_wrap_c
                      & (min_tens == MIN_TENS_W'(MIN_MAX / 10))
                      & (min_ones == ONES_W'(MIN_MAX % 10));
  assign hour_step_c  = {1'b0, hour_carry_c} + {1'b0, bus.i_inc_hour};

  // One hour step; 12-mode runs 12,01..11,12 and flips PM entering 12.
  function automatic hour_t hour_inc(input hour_t h);
    hour_t r;
    r = h;
    if (IS_12) begin
      if (h.tens == HOUR_TENS_W'(1) && h.ones == ONES_W'(2)) begin
        r.tens = '0;
        r.ones = ONES_W'(1);
      end else if (h.tens == HOUR_TENS_W'(1) && h.ones == ONES_W'(1)) begin
        r.ones = ONES_W'(2);
        r.pm   = ~h.pm;
      end else if (h.ones == ONES_W'(9)) begin
        r.tens = HOUR_TENS_W'(1);
        r.ones = '0;
      end else begin
        r.ones = h.ones + ONES_W'(1);
      end
    end else begin
      if (h.tens == HOUR_TENS_W'(2) && h.ones == ONES_W'(3)) begin
        r.tens = '0;
        r.ones = '0;
      end else if (h.ones == ONES_W'(9)) begin
        r.tens = h.tens + HOUR_TENS_W'(1);
        r.ones = '0;
      end else begin
        r.ones = h.ones + ONES_W'(1);
      end
    end
    return r;
  endfunction

  always_comb begin
    hour_mid_c = hour_inc(hour_q);
    hour_nxt_c = hour_q;
    if (hour_step_c[1]) begin
      hour_nxt_c = hour_inc(hour_mid_c);
    end else if (hour_step_c[0]) begin
      hour_nxt_c = hour_mid_c;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tick_q   <= 1'b0;
      strobe_q <= 1'b0;
      hour_q   <= HOUR_RESET;
    end else begin
      tick_q   <= bus.i_tick;
      strobe_q <= sec_adv_c;
      hour_q   <= hour_nxt_c;
    end
  end

  assign bus.o_min_tens   = min_tens;
  assign bus.o_min_ones   = min_ones;
  assign bus.o_hour_tens  = hour_q.tens;
  assign bus.o_hour_ones  = hour_q.ones;
  assign bus.o_pm         = hour_q.pm;
  assign bus.o_sec_strobe = strobe_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: a 24-hour and a 12-hour instance share stimulus.
// Reference model keeps time as plain integers on a 24-hour day; the 12-hour
// view is derived from it (hour%12, 0 shown as 12, PM when hour >= 12).
module tb_time_of_day_counter;
  import clock_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  time_of_day_counter_if bus24 ();
  time_of_day_counter_if bus12 ();

  time_of_day_counter #(.HOUR_MODE(HOUR_MODE_24)) dut24 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus24.slave));
  time_of_day_counter #(.HOUR_MODE(HOUR_MODE_12)) dut12 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus12.slave));

  int n_pass = 0;
  int n_total = 0;
  int strobe_cnt = 0;

  int m_h, m_m, m_s;
  bit m_prev, m_strobe;

  typedef struct {
    bit t, im, ih, cs;
    int eh, em, es;
    bit estb;
  } vec_t;
  vec_t vecs[10];

  function automatic void chk(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  function automatic void model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_prev = 1'b0; m_strobe = 1'b0;
  endfunction

  // One clock edge of the reference clock.
  function automatic void model_step(bit t, bit im, bit ih, bit cs);
    bit ev, sc, hc;
    ev = t && !m_prev;
    m_prev = t;
    sc = 1'b0;
    m_strobe = 1'b0;
    if (cs) m_s = 0;
    else if (ev) begin
      m_strobe = 1'b1;
      if (m_s == 59) begin m_s = 0; sc = 1'b1; end
      else m_s = m_s + 1;
    end
    hc = sc && (m_m == 59);
    m_m = (m_m + int'(sc) + int'(im)) % 60;
    m_h = (m_h + int'(hc) + int'(ih)) % 24;
  endfunction

  function automatic void chk_dut(string tag, int ht, int ho, int mt, int mo, int st, int so,
                                  int pm, int stb, int eh, int epm);
    chk({tag, " hour_tens"}, ht, eh / 10);
    chk({tag, " hour_ones"}, ho, eh % 10);
    chk({tag, " min_tens"}, mt, m_m / 10);
    chk({tag, " min_ones"}, mo, m_m % 10);
    chk({tag, " sec_tens"}, st, m_s / 10);
    chk({tag, " sec_ones"}, so, m_s % 10);
    chk({tag, " pm"}, pm, epm);
    chk({tag, " strobe"}, stb, int'(m_strobe));
  endfunction

  function automatic void check_all(string tag);
    int h12;
    h12 = (m_h % 12 == 0) ? 12 : m_h % 12;
    chk_dut({tag, "/24"}, int'(bus24.o_hour_tens), int'(bus24.o_hour_ones),
            int'(bus24.o_min_tens), int'(bus24.o_min_ones), int'(bus24.o_sec_tens),
            int'(bus24.o_sec_ones), int'(bus24.o_pm), int'(bus24.o_sec_strobe), m_h, 0);
    chk_dut({tag, "/12"}, int'(bus12.o_hour_tens), int'(bus12.o_hour_ones),
            int'(bus12.o_min_tens), int'(bus12.o_min_ones), int'(bus12.o_sec_tens),
            int'(bus12.o_sec_ones), int'(bus12.o_pm), int'(bus12.o_sec_strobe), h12,
            (m_h >= 12) ? 1 : 0);
  endfunction

  // Fixed-value check of the 24-hour instance.
  function automatic void chk_time(string nm, int eh, int em, int es);
    chk({nm, " hh"}, int'(bus24.o_hour_tens) * 10 + int'(bus24.o_hour_ones), eh);
    chk({nm, " mm"}, int'(bus24.o_min_tens) * 10 + int'(bus24.o_min_ones), em);
    chk({nm, " ss"}, int'(bus24.o_sec_tens) * 10 + int'(bus24.o_sec_ones), es);
  endfunction

  function automatic void chk12(string nm, int eh, int epm);
    chk({nm, " 12h hh"}, int'(bus12.o_hour_tens) * 10 + int'(bus12.o_hour_ones), eh);
    chk({nm, " 12h pm"}, int'(bus12.o_pm), epm);
  endfunction

  task automatic set_in(bit t, bit im, bit ih, bit cs);
    bus24.i_tick = t; bus24.i_inc_min = im; bus24.i_inc_hour = ih; bus24.i_clr_sec = cs;
    bus12.i_tick = t; bus12.i_inc_min = im; bus12.i_inc_hour = ih; bus12.i_clr_sec = cs;
  endtask

  // Inputs applied 1 ns after an edge, sampled at the next edge, checked 1 ns later.
  task automatic cycle(bit t, bit im, bit ih, bit cs, string tag);
    set_in(t, im, ih, cs);
    @(posedge clk);
    model_step(t, im, ih, cs);
    #1;
    if (bus24.o_sec_strobe) strobe_cnt++;
    check_all(tag);
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_all("reset");
  endtask

  task automatic tick_n(int n, string tag);
    repeat (n) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, tag);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, tag);
    end
  endtask

  task automatic load(int h, int m, int s);
    do_reset();
    repeat (h) cycle(1'b0, 1'b0, 1'b1, 1'b0, "load");
    repeat (m) cycle(1'b0, 1'b1, 1'b0, 1'b0, "load");
    tick_n(s, "load");
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();

    vecs[0] = '{1, 0, 0, 0, 0, 0, 1, 1};
    vecs[1] = '{1, 0, 0, 0, 0, 0, 1, 0};
    vecs[2] = '{0, 0, 0, 0, 0, 0, 1, 0};
    vecs[3] = '{0, 1, 0, 0, 0, 1, 1, 0};
    vecs[4] = '{0, 0, 1, 0, 1, 1, 1, 0};
    vecs[5] = '{1, 0, 0, 1, 1, 1, 0, 0};
    vecs[6] = '{0, 1, 1, 0, 2, 2, 0, 0};
    vecs[7] = '{1, 0, 0, 0, 2, 2, 1, 1};
    vecs[8] = '{1, 0, 1, 0, 3, 2, 1, 0};
    vecs[9] = '{0, 0, 0, 1, 3, 2, 0, 0};

    // Reset state
    do_reset();
    chk_time("reset", 0, 0, 0);
    chk12("reset", 12, 0);
    chk("reset strobe", int'(bus24.o_sec_strobe), 0);

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].t, vecs[i].im, vecs[i].ih, vecs[i].cs, $sformatf("vec%0d", i));
      chk_time($sformatf("vec%0d tbl", i), vecs[i].eh, vecs[i].em, vecs[i].es);
      chk($sformatf("vec%0d tbl strobe", i), int'(bus24.o_sec_strobe), int'(vecs[i].estb));
    end

    // 60 ticks from zero
    do_reset();
    strobe_cnt = 0;
    tick_n(59, "sixty");
    chk_time("sixty 59", 0, 0, 59);
    tick_n(1, "sixty");
    chk_time("sixty 60", 0, 1, 0);
    chk("sixty strobes", strobe_cnt, 60);

    // Midnight rollover in both modes
    load(23, 59, 58);
    chk_time("midnight pre", 23, 59, 58);
    chk12("midnight pre", 11, 1);
    tick_n(1, "midnight");
    chk_time("midnight 59", 23, 59, 59);
    tick_n(1, "midnight");
    chk_time("midnight 00", 0, 0, 0);
    chk12("midnight 00", 12, 0);

    // Tick carry plus manual minute in the same cycle
    load(0, 58, 59);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, "simul58");
    chk_time("simul58", 0, 0, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, "simul58");
    repeat (59) cycle(1'b0, 1'b1, 1'b0, 1'b0, "simul59");
    tick_n(59, "simul59");
    chk_time("simul59 pre", 0, 59, 59);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, "simul59");
    chk_time("simul59", 1, 1, 0);

    // Seconds clear wins over a tick edge
    load(0, 0, 59);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, "clrtick");
    chk_time("clrtick", 0, 0, 0);
    chk("clrtick strobe", int'(bus24.o_sec_strobe), 0);

    // Asynchronous reset mid-operation
    load(10, 20, 30);
    chk_time("areset pre", 10, 20, 30);
    chk12("areset pre", 10, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_time("areset async", 0, 0, 0);
    chk12("areset async", 12, 0);
    chk("areset strobe", int'(bus24.o_sec_strobe), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_all("areset rel");
    tick_n(1, "areset tick");
    chk_time("areset tick", 0, 0, 1);

    // Randomised run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
